alu_exec_stage: RTL

Execute stage directly downstream of the instruction decoder. Accepts the decoder's 6-bit op encoding, both operand values, destination register and write-enable, computes the RV32I ALU result, and holds it in a one-entry output register for the register-file write port. Valid/ready handshakes on both sides let the stage stall for multi-cycle shifts or a busy consumer.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_shifter.sv | 61 ++++++
 rtl/alu_exec_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I execute stage: funct3 codes, op field positions, FSM states.
package alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // in_op = {illegal, reg_form, funct3[2:0], alt}
  localparam int OP_ILLEGAL = 5;
  localparam int OP_REG     = 4;
  localparam int OP_F3_HI   = 3;
  localparam int OP_F3_LO   = 1;
  localparam int OP_ALT     = 0;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift unit: single-cycle barrel shifter, or a 1-bit-per-cycle iterative shifter
// when ALU_SERIAL_SHIFT_EN is defined.
module alu_shifter #(
  parameter int XLEN = 32
) (
`ifdef ALU_SERIAL_SHIFT_EN
  input  logic            clk,
  input  logic            rst_n,
`endif
  input  logic            start,
  input  logic            dir_right,
  input  logic            arith,
  input  logic [XLEN-1:0] operand,
  input  logic [4:0]      shamt,
  output logic            done,
  output logic [XLEN-1:0] result
);

`ifdef ALU_SERIAL_SHIFT_EN
  logic [XLEN-1:0] sh_q;
  logic [4:0]      cnt_q;
  logic            busy_q;
  logic            dir_q;
  logic            arith_q;
  logic [XLEN-1:0] step;

  assign step = dir_q ? {arith_q & sh_q[XLEN-1], sh_q[XLEN-1:1]} : {sh_q[XLEN-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (start && shamt != 5'd0) begin
      sh_q    <= operand;
      cnt_q   <= shamt;
      busy_q  <= 1'b1;
      dir_q   <= dir_right;
      arith_q <= arith;
    end else if (busy_q) begin
      sh_q  <= step;
      cnt_q <= cnt_q - 5'd1;
      if (cnt_q == 5'd1) busy_q <= 1'b0;
    end
  end

  // The last bit position is applied combinationally so the result lands in the
  // output register on the same edge the shifter goes idle.
  assign done   = (start && shamt == 5'd0) || (busy_q && cnt_q == 5'd1);
  assign result = start ? operand : step;
`else
  logic signed [XLEN-1:0] sra_res;

  assign sra_res = $signed(operand) >>> shamt;
  assign done    = start;
  assign result  = dir_right ? (arith ? sra_res : (operand >> shamt)) : (operand << shamt);
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// RV32I execute stage with a one-entry output register and valid/ready on both sides.
// Optional serial shifter selected by ALU_SERIAL_SHIFT_EN.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_op,
  input  logic [XLEN-1:0] in_rv1,
  input  logic [XLEN-1:0] in_rv2,
  input  logic [4:0]      in_rd,
  input  logic            in_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            out_we,
  output alu_state_e      dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Upstream holds in_* stable while in_valid && !in_ready; in_* is sampled only on the
  // accept edge. out_* stay stable while out_valid && !out_ready.

  alu_state_e      state_q, state_d;
  logic [2:0]      f3;
  logic            illegal;
  logic [XLEN-1:0] op_b;
  logic            is_shift;
  logic            accept;
  logic            sh_start;
  logic            sh_done;
  logic [XLEN-1:0] sh_result;
  logic            enter_shift;
  logic            complete_in;
  logic            complete_sh;
  logic            complete;
  logic [XLEN-1:0] alu_res;
  logic            we_in;
  logic [XLEN-1:0] load_res;
  logic [4:0]      load_rd;
  logic            load_we;

  assign f3       = in_op[OP_F3_HI:OP_F3_LO];
  assign illegal  = in_op[OP_ILLEGAL];
  assign op_b     = in_op[OP_REG] ? in_rv2 : sext12(in_rv2[11:0]);
  assign is_shift = !illegal && (f3 == F3_SLL || f3 == F3_SRL);
  assign in_ready = (state_q == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sh_start = accept && is_shift;
  assign we_in    = in_we && (in_rd != 5'd0) && !illegal;

  alu_shifter #(.XLEN(XLEN)) u_shifter (
`ifdef ALU_SERIAL_SHIFT_EN
    .clk       (clk),
    .rst_n     (rst_n),
`endif
    .start     (sh_start),
    .dir_right (f3 == F3_SRL),
    .arith     (in_op[OP_ALT]),
    .operand   (in_rv1),
    .shamt     (op_b[4:0]),
    .done      (sh_done),
    .result    (sh_result)
  );

  always_comb begin
    alu_res = '0;
    case (f3)
      F3_ADD:  alu_res = (in_op[OP_REG] && in_op[OP_ALT]) ? (in_rv1 - op_b) : (in_rv1 + op_b);
      F3_SLL:  alu_res = sh_result;
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_rv1) < $signed(op_b)};
      F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, in_rv1 < op_b};
      F3_XOR:  alu_res = in_rv1 ^ op_b;
      F3_SRL:  alu_res = sh_result;
      F3_OR:   alu_res = in_rv1 | op_b;
      F3_AND:  alu_res = in_rv1 & op_b;
      default: alu_res = '0;
    endcase
    if (illegal) alu_res = '0;
  end

  assign complete_in = accept && (!is_shift || sh_done);
  assign complete_sh = (state_q == S_SHIFT) && sh_done;
  assign complete    = complete_in || complete_sh;

`ifdef ALU_SERIAL_SHIFT_EN
  logic [4:0] pend_rd;
  logic       pend_we;

  assign enter_shift = sh_start && !sh_done;

  // Destination fields travel alongside a multi-cycle shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rd <= '0;
      pend_we <= 1'b0;
    end else if (sh_start) begin
      pend_rd <= in_rd;
      pend_we <= we_in;
    end
  end

  assign load_res = complete_sh ? sh_result : alu_res;
  assign load_rd  = complete_sh ? pend_rd : in_rd;
  assign load_we  = complete_sh ? pend_we : we_in;
`else
  assign enter_shift = 1'b0;
  assign load_res    = alu_res;
  assign load_rd     = in_rd;
  assign load_we     = we_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enter_shift) state_d = S_SHIFT;
      S_SHIFT: if (sh_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_we     <= 1'b0;
    end else if (complete) begin
      out_valid  <= 1'b1;
      out_result <= load_res;
      out_rd     <= load_rd;
      out_we     <= load_we;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  assign dbg_state = state_q;

endmodule
